// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: parses a length-prefixed, XOR-checksummed
// byte stream, writes little-endian words at byte addresses, and gates CPU reset.
module imem_loader #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             im_we,
  output logic [31:0]      im_addr,
  output logic [31:0]      im_wdata,
  output logic             cpu_rst,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_loaded
);

  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_WORD,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t           state_q;
  logic [7:0]       xor_q;
  logic [15:0]      len_q;
  logic [15:0]      widx_q;
  logic [1:0]       bidx_q;
  logic [23:0]      asm_q;
  logic             im_we_q;
  logic [31:0]      im_addr_q;
  logic [31:0]      im_wdata_q;
  logic             done_q;
  logic             error_q;
  logic [CNT_W-1:0] cnt_q;

  logic             accept;
  logic [7:0]       xor_d;
  logic [15:0]      len_d;
  logic             last_word;

  always_comb begin
    accept    = byte_valid && byte_ready;
    xor_d     = xor_q ^ byte_data;
    len_d     = {byte_data, len_q[7:0]};
    last_word = (widx_q == (len_q - 16'd1));
  end

  // Terminal states refuse input so trailing bytes cannot disturb the result.
  assign byte_ready   = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                        (state_q == S_WORD)   || (state_q == S_CHECK);
  assign im_we        = im_we_q;
  assign im_addr      = im_addr_q;
  assign im_wdata     = im_wdata_q;
  assign done         = done_q;
  assign error        = error_q;
  assign cpu_rst      = !done_q;
  assign words_loaded = cnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_LEN_LO;
      xor_q      <= '0;
      len_q      <= '0;
      widx_q     <= '0;
      bidx_q     <= '0;
      asm_q      <= '0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wdata_q <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      im_we_q <= 1'b0;
      if (accept) begin
        unique case (state_q)
          S_LEN_LO: begin
            xor_q      <= xor_d;
            len_q[7:0] <= byte_data;
            state_q    <= S_LEN_HI;
          end
          S_LEN_HI: begin
            xor_q  <= xor_d;
            len_q  <= len_d;
            widx_q <= '0;
            bidx_q <= '0;
            if (32'(len_d) > DEPTH_WORDS) begin
              state_q <= S_ERROR;
              error_q <= 1'b1;
            end else if (len_d == '0) begin
              state_q <= S_CHECK;
            end else begin
              state_q <= S_WORD;
            end
          end
          S_WORD: begin
            xor_q  <= xor_d;
            bidx_q <= bidx_q + 2'd1;
            unique case (bidx_q)
              2'd0: asm_q[7:0]   <= byte_data;
              2'd1: asm_q[15:8]  <= byte_data;
              2'd2: asm_q[23:16] <= byte_data;
              2'd3: begin
                // The top byte goes straight into the write data, saving a cycle.
                im_we_q    <= 1'b1;
                im_addr_q  <= {14'd0, widx_q, 2'b00};
                im_wdata_q <= {byte_data, asm_q};
                widx_q     <= widx_q + 16'd1;
                cnt_q      <= cnt_q + CNT_W'(1);
                if (last_word) state_q <= S_CHECK;
              end
            endcase
          end
          S_CHECK: begin
            if (byte_data == xor_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_ERROR;
              error_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: hand-computed images, write-strobe capture and
// status checks after each image.
`timescale 1ns/1ps
module tb_imem_loader;

  logic        CLK = 1'b0;
  logic        RST;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  logic        cpu_rst;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  imem_loader #(.DEPTH_WORDS(256), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_rst(cpu_rst), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 CLK = ~CLK;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;
  int unsigned last_acc = 0;
  int unsigned we_twice = 0;
  int unsigned both_set = 0;
  logic        we_prev  = 1'b0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  int unsigned wc[$];

  always @(posedge CLK) cyc <= cyc + 1;

  // Capture every write strobe with the edge number that launched it.
  always @(negedge CLK) begin
    if (im_we) begin
      wa.push_back(im_addr);
      wd.push_back(im_wdata);
      wc.push_back(cyc);
    end
    if (im_we && we_prev) we_twice <= we_twice + 1;
    if (done && error) both_set <= both_set + 1;
    we_prev <= im_we;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Entered and left at a falling edge; gap cycles of idle valid precede the byte.
  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    byte_valid = 1'b0;
    repeat (gap) @(negedge CLK);
    byte_data  = b;
    byte_valid = 1'b1;
    for (int i = 0; i < 20 && !byte_ready; i++) @(negedge CLK);
    chk("ready", byte_ready, 1);
    @(negedge CLK);
    last_acc   = cyc;
    byte_valid = 1'b0;
  endtask

  task automatic check_reset_vals();
    chk("rst_ready", byte_ready, 1);
    chk("rst_we", im_we, 0);
    chk("rst_addr", im_addr, 0);
    chk("rst_wdata", im_wdata, 0);
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_words", words_loaded, 0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    #2;
    @(negedge CLK);
    RST = 1'b0;
    wa.delete(); wd.delete(); wc.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] img3 [0:14];
    logic [7:0] bad1 [0:6];
    int unsigned gaps [0:6];
    int unsigned e3;
    img3 = '{8'h03, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00,
             8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hB1};
    bad1 = '{8'h01, 8'h00, 8'h05, 8'h00, 8'h08, 8'h20, 8'h2D};
    gaps = '{0, 3, 1, 2, 0, 3, 1};
    RST = 1'b1; byte_valid = 1'b0; byte_data = 8'h00;
    #2;
    check_reset_vals();
    @(negedge CLK);
    RST = 1'b0;
    wa.delete(); wd.delete(); wc.delete();

    // One-word image
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h05, 0); send_byte(8'h00, 0); send_byte(8'h08, 0); send_byte(8'h20, 0);
    e3 = last_acc;
    send_byte(8'h2C, 0);
    chk("w1_count", wa.size(), 1);
    chk("w1_addr", wa[0], 32'h0);
    chk("w1_data", wd[0], 32'h20080005);
    chk("w1_latency", wc[0], e3);
    chk("w1_done", done, 1);
    chk("w1_cpu_rst", cpu_rst, 0);
    chk("w1_words", words_loaded, 1);
    chk("w1_error", error, 0);
    chk("w1_ready", byte_ready, 0);
    byte_data = 8'hFF; byte_valid = 1'b1;
    repeat (3) @(negedge CLK);
    byte_valid = 1'b0;
    chk("w1_ignore_words", words_loaded, 1);
    chk("w1_ignore_we", wa.size(), 1);
    chk("w1_ignore_done", done, 1);

    // Three-word image, valid held high throughout
    do_reset();
    for (int i = 0; i < 14; i++) send_byte(img3[i], 0);
    chk("w3_done_before", done, 0);
    send_byte(img3[14], 0);
    chk("w3_count", wa.size(), 3);
    chk("w3_addr0", wa[0], 32'h0);
    chk("w3_addr1", wa[1], 32'h4);
    chk("w3_addr2", wa[2], 32'h8);
    chk("w3_data0", wd[0], 32'h00000013);
    chk("w3_data1", wd[1], 32'h00100093);
    chk("w3_data2", wd[2], 32'hDEADBEEF);
    chk("w3_gap01", wc[1] - wc[0], 4);
    chk("w3_gap12", wc[2] - wc[1], 4);
    chk("w3_chk_after_we", last_acc - wc[2], 1);
    chk("w3_done", done, 1);
    chk("w3_cpu_rst", cpu_rst, 0);
    chk("w3_words", words_loaded, 3);

    // Bad checksum with valid gaps
    do_reset();
    for (int i = 0; i < 7; i++) send_byte(bad1[i], gaps[i]);
    chk("bc_count", wa.size(), 1);
    chk("bc_addr", wa[0], 32'h0);
    chk("bc_data", wd[0], 32'h20080005);
    chk("bc_error", error, 1);
    chk("bc_done", done, 0);
    chk("bc_cpu_rst", cpu_rst, 1);
    chk("bc_ready", byte_ready, 0);

    // Oversize length 257
    do_reset();
    send_byte(8'h01, 0);
    chk("ov_error_early", error, 0);
    send_byte(8'h01, 0);
    chk("ov_error", error, 1);
    chk("ov_ready", byte_ready, 0);
    chk("ov_cpu_rst", cpu_rst, 1);
    repeat (3) @(negedge CLK);
    chk("ov_no_we", wa.size(), 0);

    // Zero-length image
    do_reset();
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    chk("z_done", done, 1);
    chk("z_words", words_loaded, 0);
    chk("z_no_we", wa.size(), 0);
    chk("z_error", error, 0);

    // Reset mid-image, then a fresh load
    do_reset();
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h93, 0); send_byte(8'h00, 0);
    chk("mr_words_before", words_loaded, 1);
    #1;
    RST = 1'b1;
    #1;
    check_reset_vals();
    @(negedge CLK);
    RST = 1'b0;
    wa.delete(); wd.delete(); wc.delete();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h05, 0); send_byte(8'h00, 0); send_byte(8'h08, 0); send_byte(8'h20, 0);
    send_byte(8'h2C, 0);
    chk("mr_count", wa.size(), 1);
    chk("mr_addr", wa[0], 32'h0);
    chk("mr_data", wd[0], 32'h20080005);
    chk("mr_done", done, 1);
    chk("mr_words", words_loaded, 1);

    chk("we_never_back_to_back", we_twice, 0);
    chk("done_error_exclusive", both_set, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
